// File: rtl/relu_node_stream_queue.sv
// Ping-pong queue that captures whole ReLU layer vectors and streams (index, value)
// pairs to the next layer over valid/ready, optionally skipping zero activations.
module relu_node_stream_queue #(
  parameter int unsigned NODES      = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SKIP_ZERO  = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load_valid,
  output logic                              load_ready,
  input  logic [NODES*DATA_WIDTH-1:0]       load_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NODES)-1:0]          out_index,
  output logic [DATA_WIDTH-1:0]             out_data,
  output logic                              out_last,
  output logic                              bank_done,
  output logic                              queue_empty
);

  localparam int unsigned INDEX_WIDTH = $clog2(NODES);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NODES - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   bank_mem [2][NODES];
  logic [1:0]              full_q, full_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [INDEX_WIDTH-1:0]  cursor_q, cursor_d;

  logic                    out_valid_d;
  logic [INDEX_WIDTH-1:0]  out_index_d;
  logic [DATA_WIDTH-1:0]   out_data_d;
  logic                    out_last_d;
  logic                    bank_done_d;

  logic                    load_fire;
  logic                    slot_free;
  logic                    at_last;
  logic                    emit;
  logic [DATA_WIDTH-1:0]   entry;

  // Handshake qualifiers derive from registered state only.
  assign load_ready  = reset & ~(full_q[0] & full_q[1]);
  assign load_fire   = load_valid & load_ready;
  assign slot_free   = ~out_valid | out_ready;
  assign queue_empty = ~full_q[0] & ~full_q[1] & ~out_valid;

  assign entry   = bank_mem[rd_ptr_q][cursor_q];
  assign at_last = (cursor_q == LAST_IDX);
  assign emit    = (SKIP_ZERO == 0) | (entry != '0) | at_last;

  // Bank storage: whole vector written on accept; node 0 lives in the MSBs.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      for (int unsigned i = 0; i < NODES; i++) begin
        bank_mem[wr_ptr_q][i] <= load_data[(NODES-1-i)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      full_q    <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cursor_q  <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      out_last  <= 1'b0;
      bank_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      full_q    <= full_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cursor_q  <= cursor_d;
      out_valid <= out_valid_d;
      out_index <= out_index_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      bank_done <= bank_done_d;
    end
  end

  // Next-state logic: load bookkeeping first, then the drain FSM.
  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cursor_d    = cursor_q;
    out_valid_d = out_valid;
    out_index_d = out_index;
    out_data_d  = out_data;
    out_last_d  = out_last;
    bank_done_d = 1'b0;

    if (load_fire) begin
      full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d         = ~wr_ptr_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (slot_free) begin
          out_valid_d = 1'b0;
        end
        if (full_d[rd_ptr_q]) begin
          state_d  = ST_DRAIN;
          cursor_d = '0;
        end
      end

      ST_DRAIN: begin
        if (slot_free) begin
          if (emit) begin
            out_valid_d = 1'b1;
            out_index_d = cursor_q;
            out_data_d  = entry;
            out_last_d  = at_last;
          end else begin
            out_valid_d = 1'b0;
          end
          if (at_last) begin
            // Release the bank; carry straight on if the other one is waiting.
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            cursor_d         = '0;
            bank_done_d      = 1'b1;
            state_d          = full_d[~rd_ptr_q] ? ST_DRAIN : ST_IDLE;
          end else begin
            cursor_d = cursor_q + INDEX_WIDTH'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_relu_node_stream_queue.sv
// Directed bench: one queue instance with zero skipping off (a) and one with it on (b),
// sharing stimulus; each test checks the instance whose behaviour it targets.
module tb_relu_node_stream_queue;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        out_ready;

  logic        load_ready_a, out_valid_a, out_last_a, bank_done_a, queue_empty_a;
  logic [1:0]  out_index_a;
  logic [7:0]  out_data_a;
  logic        load_ready_b, out_valid_b, out_last_b, bank_done_b, queue_empty_b;
  logic [1:0]  out_index_b;
  logic [7:0]  out_data_b;

  int tests = 0;
  int fails = 0;

  relu_node_stream_queue #(.NODES(4), .DATA_WIDTH(8), .SKIP_ZERO(0)) dut_a (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_a),
    .load_data(load_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_index(out_index_a), .out_data(out_data_a), .out_last(out_last_a),
    .bank_done(bank_done_a), .queue_empty(queue_empty_a)
  );

  relu_node_stream_queue #(.NODES(4), .DATA_WIDTH(8), .SKIP_ZERO(1)) dut_b (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready_b),
    .load_data(load_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_index(out_index_b), .out_data(out_data_b), .out_last(out_last_b),
    .bank_done(bank_done_b), .queue_empty(queue_empty_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat word: {bank_done, out_valid, out_last, out_index, out_data}
  logic [12:0] obs_a, obs_b;
  assign obs_a = {bank_done_a, out_valid_a, out_last_a, out_index_a, out_data_a};
  assign obs_b = {bank_done_b, out_valid_b, out_last_b, out_index_b, out_data_b};

  function automatic logic [12:0] bw(input logic bd, input logic v, input logic l,
                                     input logic [1:0] i, input logic [7:0] d);
    return {bd, v, l, i, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset      = 1'b0;
    load_valid = 1'b0;
    out_ready  = 1'b1;
    step;
    reset = 1'b1;
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    load_valid = 1'b0;
    load_data  = '0;
    out_ready  = 1'b1;

    // Reset state
    do_reset;
    check("rst_beat_a", 32'(obs_a), 32'(0));
    check("rst_beat_b", 32'(obs_b), 32'(0));
    check("rst_empty_a", 32'(queue_empty_a), 32'(1));
    check("rst_lready_a", 32'(load_ready_a), 32'(1));

    // Test 1/2: {11,00,33,44}, full stream on a, zero skipped on b
    load_data  = {8'h11, 8'h00, 8'h33, 8'h44};
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    check("t1_latency_a", 32'({bank_done_a, out_valid_a}), 32'(0));
    step;
    check("t1_idx0_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd0, 8'h11)));
    check("t2_idx0_b", 32'(obs_b), 32'(bw(1'b0, 1'b1, 1'b0, 2'd0, 8'h11)));
    step;
    check("t1_idx1_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd1, 8'h00)));
    check("t2_gap_b", 32'({bank_done_b, out_valid_b}), 32'(0));
    step;
    check("t1_idx2_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd2, 8'h33)));
    check("t2_idx2_b", 32'(obs_b), 32'(bw(1'b0, 1'b1, 1'b0, 2'd2, 8'h33)));
    step;
    check("t1_idx3_a", 32'(obs_a), 32'(bw(1'b1, 1'b1, 1'b1, 2'd3, 8'h44)));
    check("t2_idx3_b", 32'(obs_b), 32'(bw(1'b1, 1'b1, 1'b1, 2'd3, 8'h44)));
    step;
    check("t1_after_a", 32'({bank_done_a, out_valid_a}), 32'(0));
    check("t1_empty_a", 32'(queue_empty_a), 32'(1));
    check("t2_empty_b", 32'(queue_empty_b), 32'(1));

    // Test 2: all-zero vector on b yields a single last beat
    do_reset;
    load_data  = 32'h0;
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step;
      check("t2z_skip_b", 32'({bank_done_b, out_valid_b}), 32'(0));
    end
    step;
    check("t2z_last_b", 32'(obs_b), 32'(bw(1'b1, 1'b1, 1'b1, 2'd3, 8'h00)));
    step;
    check("t2z_empty_b", 32'(queue_empty_b), 32'(1));

    // Test 3: backpressure holds idx0 for five cycles
    do_reset;
    out_ready  = 1'b0;
    load_data  = {8'h11, 8'h00, 8'h33, 8'h44};
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step;
      check("t3_hold_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd0, 8'h11)));
    end
    out_ready = 1'b1;
    step;
    check("t3_idx1_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd1, 8'h00)));
    step;
    check("t3_idx2_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd2, 8'h33)));
    step;
    check("t3_idx3_a", 32'(obs_a), 32'(bw(1'b1, 1'b1, 1'b1, 2'd3, 8'h44)));
    step;
    check("t3_done_a", 32'({bank_done_a, out_valid_a}), 32'(0));

    // Test 4/6: ping-pong A,B; C held valid until accepted into freed bank
    do_reset;
    out_ready  = 1'b0;
    load_valid = 1'b1;
    load_data  = {8'h01, 8'h02, 8'h03, 8'h04};
    step;
    check("t4_lready_1_a", 32'(load_ready_a), 32'(1));
    load_data = {8'h05, 8'h06, 8'h07, 8'h08};
    step;
    load_data = {8'h09, 8'h0a, 8'h0b, 8'h0c};
    check("t4_a0_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd0, 8'h01)));
    check("t4_full_a", 32'(load_ready_a), 32'(0));
    step;
    check("t4_a0_hold_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd0, 8'h01)));
    check("t4_full2_a", 32'(load_ready_a), 32'(0));
    out_ready = 1'b1;
    for (int j = 1; j < 12; j++) begin
      step;
      check("t4_beat_a", 32'(obs_a),
            32'(bw((j % 4) == 3, 1'b1, (j % 4) == 3, 2'(j % 4), 8'(j + 1))));
      if (j < 3) check("t4_lready_lo_a", 32'(load_ready_a), 32'(0));
      if (j == 3) check("t4_lready_rel_a", 32'(load_ready_a), 32'(1));
      if (j == 4) begin
        check("t6_once_a", 32'(load_ready_a), 32'(0));
        load_valid = 1'b0;
      end
    end
    step;
    check("t4_end_a", 32'({bank_done_a, out_valid_a}), 32'(0));
    check("t4_empty_a", 32'(queue_empty_a), 32'(1));
    step;
    check("t6_nodup_a", 32'(out_valid_a), 32'(0));

    // Test 5: reset while idx1 presented
    do_reset;
    load_data  = {8'h11, 8'h00, 8'h33, 8'h44};
    load_valid = 1'b1;
    step;
    load_valid = 1'b0;
    step;
    step;
    check("t5_idx1_a", 32'(obs_a), 32'(bw(1'b0, 1'b1, 1'b0, 2'd1, 8'h00)));
    reset = 1'b0;
    step;
    check("t5_lready_inrst_a", 32'(load_ready_a), 32'(0));
    reset = 1'b1;
    #1;
    check("t5_beat_a", 32'(obs_a), 32'(0));
    check("t5_empty_a", 32'(queue_empty_a), 32'(1));
    check("t5_lready_a", 32'(load_ready_a), 32'(1));
    for (int k = 0; k < 3; k++) begin
      step;
      check("t5_nostale_a", 32'(out_valid_a), 32'(0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
